fpa_share_arbiter: RTL and testbench

- Shares one 8-bit floating-point adder datapath/controller pair among N requesters.
- Round-robin arbitration picks one pending requester and latches its operands. It then pulses the adder start, waits for adder done, and returns the tagged result.
- A watchdog counter aborts a hung operation, resets the adder, and returns a timeout response.
- Sits between client logic (operand sources) and the adder top level.

---
 rtl/fpa_pkg.sv | 25 ++
 rtl/fpa_share_arbiter_rr_pick.sv | 45 ++++
 rtl/fpa_share_arbiter.sv | 151 +++++++++++++++
 tb/tb_fpa_share_arbiter.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpa_pkg.sv
// fpa_pkg
// Shared definitions for the 8-bit floating-point adder sharing logic.
//   - controller state encodings (3-bit constants)
//   - operand field positions: sign[7] exp[6:3] mant[2:0]
//   - operand and exception-flag widths
package fpa_pkg;

    // Arbiter controller states
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] RESP  = 3'd3;
    localparam logic [2:0] ABORT = 3'd4;
    localparam logic [2:0] DRAIN = 3'd5;

    // Operand field layout
    localparam int SIGN     = 7;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 3;
    localparam int MANT_MSB = 2;

    localparam int OP_W  = SIGN + 1;
    localparam int EXC_W = 4;

endpackage

// File: rtl/fpa_share_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin selector. Searches req starting at ptr and
// wrapping upward; reports the first set bit as a one-hot grant and index.
// Ports:
//   req   in  N    request vector
//   ptr   in  IDW  search start position (0..N-1)
//   gnt   out N    one-hot grant, all zero when nothing is requested
//   idx   out IDW  index of the granted requester (0 when none)
//   found out 1    at least one request is set
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           found
);

    localparam int PW = $clog2(N);

    int          pos;
    logic [PW-1:0] sel;

    // Walk the N positions in rotated order; the first hit wins and
    // later hits are masked by 'found'.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            sel = PW'(pos);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                idx      = IDW'(sel);
            end
        end
    end

endmodule

// File: rtl/fpa_share_arbiter.sv
// fpa_share_arbiter
// Shares one 8-bit floating-point adder among N requesters. A round-robin
// pick latches one requester's operands, pulses the adder start, waits for
// done (guarded by a watchdog) and returns a tagged response.
// Ports:
//   clk, clr            clock and synchronous active-high reset
//   req, op_a, op_b     per-requester request level and packed operands
//   gnt                 one-hot pulse when a requester's operands are taken
//   busy                controller is not idle
//   rsp_valid/id/ans/except/timeout  one-cycle tagged response
//   fpa_clr/start/a/b   control and operands toward the adder
//   fpa_ans/except/done result and done level from the adder
module fpa_share_arbiter
    import fpa_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 32,
    parameter int IDW     = 3
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [N-1:0]        req,
    input  logic [OP_W*N-1:0]   op_a,
    input  logic [OP_W*N-1:0]   op_b,
    output logic [N-1:0]        gnt,
    output logic                busy,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [OP_W-1:0]     rsp_ans,
    output logic [EXC_W-1:0]    rsp_except,
    output logic                rsp_timeout,
    output logic                fpa_clr,
    output logic                fpa_start,
    output logic [OP_W-1:0]     fpa_a,
    output logic [OP_W-1:0]     fpa_b,
    input  logic [OP_W-1:0]     fpa_ans,
    input  logic [EXC_W-1:0]    fpa_except,
    input  logic                fpa_done
);

    localparam int WDW = $clog2(TIMEOUT) + 1;

    logic [2:0]       state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id_q;
    logic [WDW-1:0]   wd;
    logic [OP_W-1:0]  a_q, b_q, ans_q;
    logic [EXC_W-1:0] exc_q;

    logic [N-1:0]     pick_gnt;
    logic [IDW-1:0]   pick_idx;
    logic             pick_found;
    logic [OP_W-1:0]  sel_a, sel_b;
    logic [IDW-1:0]   next_ptr;
    logic             wd_last;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // One-hot operand mux driven by the picker's grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_gnt[i]) begin
                sel_a = op_a[i*OP_W +: OP_W];
                sel_b = op_b[i*OP_W +: OP_W];
            end
        end
    end

    assign next_ptr = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
    assign wd_last  = (wd == WDW'(TIMEOUT - 1));

    // Controller state, operand/result latches and watchdog. The watchdog
    // bounds both the wait for done and the wait for done to drop again.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id_q   <= '0;
            wd     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            ans_q  <= '0;
            exc_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        id_q  <= pick_idx;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wd <= wd + 1'b1;
                    // done wins over a watchdog expiry in the same cycle
                    if (fpa_done) begin
                        ans_q <= fpa_ans;
                        exc_q <= fpa_except;
                        state <= RESP;
                    end else if (wd_last) begin
                        ans_q <= '0;
                        exc_q <= '0;
                        state <= ABORT;
                    end
                end
                RESP, ABORT: begin
                    rr_ptr <= next_ptr;
                    wd     <= '0;
                    state  <= DRAIN;
                end
                DRAIN: begin
                    // a level-held done must fall before the next issue
                    if (!fpa_done || wd_last) begin
                        state <= IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode from state; clr masks them so a reset cycle is quiet.
    assign gnt         = (!clr && state == IDLE) ? pick_gnt : '0;
    assign busy        = !clr && (state != IDLE);
    assign fpa_start   = !clr && (state == ISSUE);
    assign rsp_valid   = !clr && (state == RESP || state == ABORT);
    assign rsp_timeout = !clr && (state == ABORT);
    assign fpa_clr     = clr || (state == ABORT);

    assign rsp_id     = id_q;
    assign rsp_ans    = ans_q;
    assign rsp_except = exc_q;
    assign fpa_a      = a_q;
    assign fpa_b      = b_q;

endmodule

// File: tb/tb_fpa_share_arbiter.sv
// tb_fpa_share_arbiter
// Directed bench for fpa_share_arbiter (N=4, TIMEOUT=32). A small adder
// model answers fpa_start after done_delay cycles with a+b; selected tests
// take direct control of the adder return signals instead.
module tb_fpa_share_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 32;
    localparam int IDW     = 3;

    logic             clk = 1'b0;
    logic             clr;
    logic [N-1:0]     req;
    logic [8*N-1:0]   op_a, op_b;
    logic [N-1:0]     gnt;
    logic             busy, rsp_valid, rsp_timeout, fpa_clr, fpa_start;
    logic [IDW-1:0]   rsp_id;
    logic [7:0]       rsp_ans, fpa_a, fpa_b, fpa_ans;
    logic [3:0]       rsp_except, fpa_except;
    logic             fpa_done;

    int checks = 0;
    int errors = 0;

    // Adder model and direct override
    logic       force_mode;
    logic       tb_done;
    logic [7:0] tb_ans;
    logic [3:0] tb_exc;
    int         done_delay, done_hold;
    logic       m_done;
    logic [7:0] m_ans;
    logic [3:0] m_exc;
    int         m_cnt, m_hold;

    assign fpa_done   = force_mode ? tb_done : m_done;
    assign fpa_ans    = force_mode ? tb_ans  : m_ans;
    assign fpa_except = force_mode ? tb_exc  : m_exc;

    fpa_share_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk         (clk),
        .clr         (clr),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .gnt         (gnt),
        .busy        (busy),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_ans     (rsp_ans),
        .rsp_except  (rsp_except),
        .rsp_timeout (rsp_timeout),
        .fpa_clr     (fpa_clr),
        .fpa_start   (fpa_start),
        .fpa_a       (fpa_a),
        .fpa_b       (fpa_b),
        .fpa_ans     (fpa_ans),
        .fpa_except  (fpa_except),
        .fpa_done    (fpa_done)
    );

    always #5 clk = ~clk;

    // Adder model: done rises done_delay cycles after start, stays for
    // done_hold cycles; result is a+b, flags are the exponent field of b.
    always @(posedge clk) begin
        if (fpa_clr) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_hold <= 0;
            m_ans  <= 8'h00;
            m_exc  <= 4'h0;
        end else if (fpa_start) begin
            m_cnt  <= done_delay;
            m_done <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_hold <= done_hold;
                m_ans  <= fpa_a + fpa_b;
                m_exc  <= fpa_b[6:3];
            end
        end else if (m_done) begin
            if (m_hold <= 1) m_done <= 1'b0;
            else m_hold <= m_hold - 1;
        end
    end

    // Advance to the drive point of the next cycle (away from the edge)
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            #1;
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("[TB] FAIL %s idle: busy still %b after %0d cycles, wanted 0", name, busy, n);
        end
    endtask

    task automatic test_reset;
        clr = 1'b1;
        tick();
        #1;
        checks++;
        if ({gnt, busy, rsp_valid, rsp_timeout, fpa_start, rsp_id, rsp_ans, rsp_except, fpa_a, fpa_b} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b gnt=%b rsp_valid=%b rsp_id=%0d fpa_a=%h, wanted all 0", busy, gnt, rsp_valid, rsp_id, fpa_a);
        end
        checks++;
        if (fpa_clr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_fpa_clr: got %b wanted 1", fpa_clr);
        end
        tick();
        clr = 1'b0;
        #1;
        checks++;
        if (fpa_clr !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_release: got fpa_clr=%b busy=%b gnt=%b wanted 0/0/0000", fpa_clr, busy, gnt);
        end
    endtask

    task automatic test_single;
        int rc;
        force_mode = 1'b0;
        done_delay = 5;
        done_hold  = 1;
        tick();
        req  = 4'b0001;
        op_a = 32'h0000_0038;
        op_b = 32'h0000_0038;
        #1;
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_gnt: got gnt=%b busy=%b wanted 0001/0", gnt, busy);
        end
        tick();
        req = 4'b0000;
        #1;
        checks++;
        if (fpa_start !== 1'b1 || gnt !== 4'b0000 || fpa_a !== 8'h38 || fpa_b !== 8'h38 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_issue: got start=%b gnt=%b a=%h b=%h busy=%b wanted 1/0000/38/38/1", fpa_start, gnt, fpa_a, fpa_b, busy);
        end
        rc = -1;
        for (int c = 2; c <= 40 && rc < 0; c++) begin
            tick();
            #1;
            if (c == 2) begin
                checks++;
                if (fpa_start !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL single_start_width: got start=%b in cycle 2 wanted 0", fpa_start);
                end
            end
            if (rsp_valid) begin
                rc = c;
                checks++;
                if (rsp_id !== 3'd0 || rsp_ans !== 8'h70 || rsp_except !== 4'h7 || rsp_timeout !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL single_rsp: got id=%0d ans=%h exc=%h to=%b wanted 0/70/7/0", rsp_id, rsp_ans, rsp_except, rsp_timeout);
                end
            end
        end
        checks++;
        if (rc != 8) begin
            errors++;
            $display("[TB] FAIL single_latency: got rsp cycle %0d wanted 8", rc);
        end
        wait_idle("single");
    endtask

    task automatic test_fairness;
        int exp_g [5] = '{0, 1, 2, 3, 0};
        int gl [8];
        logic [IDW-1:0] rid [5];
        logic [7:0]     rans [5];
        int ng, nr;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        force_mode = 1'b0;
        done_delay = 5;
        done_hold  = 1;
        op_a = {8'h40, 8'h30, 8'h20, 8'h10};
        op_b = {8'h04, 8'h03, 8'h02, 8'h01};
        req  = 4'b1111;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 300 && nr < 5; c++) begin
            if (c != 0) tick();
            #1;
            if (gnt != 4'b0000 && ng < 8) begin
                gl[ng] = -1;
                for (int b = 0; b < N; b++) if (gnt[b]) gl[ng] = b;
                ng++;
            end
            if (rsp_valid && nr < 5) begin
                rid[nr]  = rsp_id;
                rans[nr] = rsp_ans;
                nr++;
            end
        end
        req = 4'b0000;
        checks++;
        if (nr != 5 || ng < 5) begin
            errors++;
            $display("[TB] FAIL fair_count: got %0d grants %0d responses wanted 5/5", ng, nr);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (gl[i] != exp_g[i] || int'(rid[i]) != exp_g[i] || rans[i] !== 8'(8'h11 * (exp_g[i] + 1))) begin
                    errors++;
                    $display("[TB] FAIL fair_op%0d: got gnt=%0d rsp_id=%0d ans=%h wanted %0d/%0d/%h", i, gl[i], rid[i], rans[i], exp_g[i], exp_g[i], 8'(8'h11 * (exp_g[i] + 1)));
                end
            end
        end
        wait_idle("fairness");
    endtask

    task automatic test_timeout;
        int rc, nclr;
        force_mode = 1'b1;
        tb_done = 1'b0;
        tb_ans  = 8'hEE;
        tb_exc  = 4'hF;
        tick();
        req = 4'b0001;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL timeout_gnt: got %b wanted 0001", gnt);
        end
        rc = -1;
        nclr = 0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            #1;
            if (fpa_clr) nclr++;
            if (rsp_valid && rc < 0) begin
                rc = c;
                checks++;
                if (rsp_timeout !== 1'b1 || rsp_ans !== 8'h00 || rsp_except !== 4'h0 || rsp_id !== 3'd0 || fpa_clr !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL timeout_rsp: got to=%b ans=%h exc=%h id=%0d clr=%b wanted 1/00/0/0/1", rsp_timeout, rsp_ans, rsp_except, rsp_id, fpa_clr);
                end
            end
            if (c > 2 && !busy) break;
        end
        checks++;
        if (rc != 34 || nclr != 1) begin
            errors++;
            $display("[TB] FAIL timeout_timing: got rsp cycle %0d fpa_clr pulses %0d wanted 34/1", rc, nclr);
        end
        wait_idle("timeout");
        // The next request after an abort is served normally
        force_mode = 1'b0;
        done_delay = 3;
        req = 4'b0100;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL after_timeout_gnt: got %b wanted 0100", gnt);
        end
        rc = -1;
        for (int c = 1; c <= 40 && rc < 0; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            #1;
            if (rsp_valid) begin
                rc = c;
                checks++;
                if (rsp_id !== 3'd2 || rsp_timeout !== 1'b0 || rsp_ans !== 8'h33) begin
                    errors++;
                    $display("[TB] FAIL after_timeout_rsp: got id=%0d to=%b ans=%h wanted 2/0/33", rsp_id, rsp_timeout, rsp_ans);
                end
            end
        end
        checks++;
        if (rc != 6) begin
            errors++;
            $display("[TB] FAIL after_timeout_latency: got %0d wanted 6", rc);
        end
        wait_idle("after_timeout");
    endtask

    task automatic test_collision;
        int rc, nclr;
        force_mode = 1'b1;
        tb_done = 1'b0;
        tb_ans  = 8'h5A;
        tb_exc  = 4'hC;
        tick();
        req = 4'b0010;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL collide_gnt: got %b wanted 0010", gnt);
        end
        rc = -1;
        nclr = 0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            if (c == 33) tb_done = 1'b1;
            if (c == 34) tb_done = 1'b0;
            #1;
            if (fpa_clr) nclr++;
            if (rsp_valid && rc < 0) begin
                rc = c;
                checks++;
                if (rsp_timeout !== 1'b0 || rsp_ans !== 8'h5A || rsp_except !== 4'hC || rsp_id !== 3'd1) begin
                    errors++;
                    $display("[TB] FAIL collide_rsp: got to=%b ans=%h exc=%h id=%0d wanted 0/5a/c/1", rsp_timeout, rsp_ans, rsp_except, rsp_id);
                end
            end
            if (c > 2 && !busy) break;
        end
        checks++;
        if (rc != 34 || nclr != 0) begin
            errors++;
            $display("[TB] FAIL collide_timing: got rsp cycle %0d fpa_clr pulses %0d wanted 34/0", rc, nclr);
        end
        wait_idle("collision");
    endtask

    task automatic test_sticky_done;
        int gc, r1;
        force_mode = 1'b1;
        tb_done = 1'b0;
        tb_ans  = 8'h66;
        tb_exc  = 4'h1;
        tick();
        req = 4'b0001;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL sticky_first_gnt: got %b wanted 0001", gnt);
        end
        gc = -1;
        r1 = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 1) req = 4'b0010;
            if (c == 4) tb_done = 1'b1;
            if (c == 9) tb_done = 1'b0;
            if (gc > 0 && c == gc + 1) req = 4'b0000;
            if (gc > 0 && c == gc + 2) tb_done = 1'b1;
            if (gc > 0 && c == gc + 3) tb_done = 1'b0;
            #1;
            if (rsp_valid && r1 < 0) begin
                r1 = c;
                checks++;
                if (rsp_id !== 3'd0 || rsp_ans !== 8'h66) begin
                    errors++;
                    $display("[TB] FAIL sticky_rsp: got id=%0d ans=%h wanted 0/66", rsp_id, rsp_ans);
                end
            end
            if (gnt != 4'b0000 && gc < 0) begin
                gc = c;
                checks++;
                if (gnt !== 4'b0010) begin
                    errors++;
                    $display("[TB] FAIL sticky_second_gnt: got %b wanted 0010", gnt);
                end
            end
            if (gc > 0 && c > gc + 4 && !busy) break;
        end
        checks++;
        if (r1 != 5 || gc != 10) begin
            errors++;
            $display("[TB] FAIL sticky_timing: got rsp cycle %0d gnt cycle %0d wanted 5/10", r1, gc);
        end
        wait_idle("sticky");
    endtask

    task automatic test_reset_mid_wait;
        int nrsp, rc;
        force_mode = 1'b1;
        tb_done = 1'b0;
        done_delay = 3;
        tick();
        req = 4'b0001;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL midrst_gnt: got %b wanted 0001", gnt);
        end
        nrsp = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            if (c == 3) clr = 1'b1;
            if (c == 4) begin
                clr = 1'b0;
                req = 4'b1010;
                force_mode = 1'b0;
            end
            #1;
            if (rsp_valid) nrsp++;
            if (c == 3) begin
                checks++;
                if (fpa_clr !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL midrst_clr_cycle: got fpa_clr=%b busy=%b wanted 1/0", fpa_clr, busy);
                end
            end
            if (c == 4) begin
                checks++;
                if ({rsp_id, rsp_ans, rsp_except, fpa_a, fpa_b, busy, fpa_clr} !== '0) begin
                    errors++;
                    $display("[TB] FAIL midrst_cleared: got id=%0d ans=%h a=%h b=%h busy=%b clr=%b wanted all 0", rsp_id, rsp_ans, fpa_a, fpa_b, busy, fpa_clr);
                end
                checks++;
                if (gnt !== 4'b0010) begin
                    errors++;
                    $display("[TB] FAIL midrst_ptr: got gnt=%b wanted 0010", gnt);
                end
            end
        end
        checks++;
        if (nrsp != 0) begin
            errors++;
            $display("[TB] FAIL midrst_no_rsp: got %0d responses wanted 0", nrsp);
        end
        rc = -1;
        for (int c = 1; c <= 40 && rc < 0; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            #1;
            if (rsp_valid) begin
                rc = c;
                checks++;
                if (rsp_id !== 3'd1 || rsp_timeout !== 1'b0 || rsp_ans !== 8'h22) begin
                    errors++;
                    $display("[TB] FAIL midrst_next_rsp: got id=%0d to=%b ans=%h wanted 1/0/22", rsp_id, rsp_timeout, rsp_ans);
                end
            end
        end
        checks++;
        if (rc < 0) begin
            errors++;
            $display("[TB] FAIL midrst_next_timeout: got no response wanted one");
        end
        wait_idle("midrst");
    endtask

    initial begin
        clr        = 1'b1;
        req        = '0;
        op_a       = '0;
        op_b       = '0;
        force_mode = 1'b0;
        tb_done    = 1'b0;
        tb_ans     = 8'h00;
        tb_exc     = 4'h0;
        done_delay = 5;
        done_hold  = 1;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_collision();
        test_sticky_done();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
